// File: rtl/inst_r_pkg.sv
// Shared encoding constants for the RV32 R-type instruction encoder.
// Holds the OP opcode, the op-code enum, funct3/funct7 values and a decode helper.
// Config macro: INST_R_ENCODER_M_EXT_EN adds the M-extension op codes 10-17.
package inst_r_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_SLL  = 5'd2,
        OP_SLT  = 5'd3,
        OP_SLTU = 5'd4,
        OP_XOR  = 5'd5,
        OP_SRL  = 5'd6,
        OP_SRA  = 5'd7,
        OP_OR   = 5'd8,
        OP_AND  = 5'd9
`ifdef INST_R_ENCODER_M_EXT_EN
        ,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
`endif
    } op_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef INST_R_ENCODER_M_EXT_EN
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

    typedef struct packed {
        logic       legal;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } dec_t;

    function automatic dec_t decode_op(input logic [4:0] op);
        dec_t d;
        d.legal  = 1'b1;
        d.funct3 = F3_ADD_SUB;
        d.funct7 = F7_BASE;
        case (op)
            OP_ADD:  d.funct3 = F3_ADD_SUB;
            OP_SUB:  d.funct7 = F7_ALT;
            OP_SLL:  d.funct3 = F3_SLL;
            OP_SLT:  d.funct3 = F3_SLT;
            OP_SLTU: d.funct3 = F3_SLTU;
            OP_XOR:  d.funct3 = F3_XOR;
            OP_SRL:  d.funct3 = F3_SRL_SRA;
            OP_SRA: begin
                d.funct3 = F3_SRL_SRA;
                d.funct7 = F7_ALT;
            end
            OP_OR:   d.funct3 = F3_OR;
            OP_AND:  d.funct3 = F3_AND;
`ifdef INST_R_ENCODER_M_EXT_EN
            // M ops are contiguous, so funct3 is simply the offset from MUL.
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                d.funct7 = F7_MULDIV;
                d.funct3 = 3'(op - OP_MUL);
            end
`endif
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/inst_r_fifo.sv
// 2-entry FIFO; output taken straight from the head register.
// Latency: a push into an empty FIFO is visible after the same edge.
// Backpressure: full is a registered flag; pushes while full and pops while empty are ignored.
// Ports: clk, rst (async high), flush (sync clear), push/push_data, pop, full, valid, data.
module inst_r_fifo #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         valid,
    output logic [W-1:0] data
);

    logic [1:0]   count;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push_ok;
    logic         pop_ok;

    assign full    = (count == 2'd2);
    assign valid   = (count != 2'd0);
    assign data    = head;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= RST_VAL;
            tail  <= RST_VAL;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (push_ok && !pop_ok) begin
                if (count == 2'd0) head <= push_data;
                else               tail <= push_data;
            end else if (pop_ok) begin
                // push_ok cannot coincide with count==2 because full blocks it.
                if (count == 2'd2)  head <= tail;
                else if (push_ok)   head <= push_data;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/inst_r_encoder.sv
// RV32 R-type instruction encoder with byte-address tagging and 2-deep output buffer.
// Latency: accepted request visible on out_* after one edge; one instruction/cycle sustained.
// Backpressure: in_ready low while the buffer holds two entries; illegal ops are consumed and set err.
// Ports: clk, rst, flush, in_valid/in_ready/in_op/in_rd/in_rs1/in_rs2,
//        out_valid/out_ready/out_word/out_addr, err.
// Config macro: INST_R_ENCODER_M_EXT_EN enables MUL/DIV/REM op codes 10-17.
module inst_r_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);
    import inst_r_pkg::*;

    localparam int W = 32 + ADDR_W;

    dec_t              dec;
    logic [31:0]       word;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              push;
    logic              full;
    logic [W-1:0]      fifo_data;

    assign dec    = decode_op(in_op);
    assign word   = {dec.funct7, in_rs2, in_rs1, dec.funct3, in_rd, OP_R};
    assign accept = in_valid & in_ready;
    // Illegal ops complete the handshake but never reach the buffer.
    assign push   = accept & dec.legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= BASE_ADDR;
            err  <= 1'b0;
        end else if (flush) begin
            addr <= BASE_ADDR;
            err  <= 1'b0;
        end else if (accept) begin
            if (dec.legal) addr <= addr + ADDR_W'(4);
            else           err  <= 1'b1;
        end
    end

    inst_r_fifo #(
        .W       (W),
        .RST_VAL ({32'h0, BASE_ADDR})
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data ({word, addr}),
        .pop       (out_valid & out_ready),
        .full      (full),
        .valid     (out_valid),
        .data      (fifo_data)
    );

    assign in_ready = ~full;
    assign out_word = fifo_data[W-1 -: 32];
    assign out_addr = fifo_data[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_r_encoder.sv
// Bench for inst_r_encoder: directed scenarios then random traffic against a queue model.
// Two instances share inputs: default widths, and ADDR_W=4/BASE_ADDR=0xC for wrap checks.
// Config macro: INST_R_ENCODER_M_EXT_EN selects the M-extension expectations.
module tb_inst_r_encoder;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [4:0]  in_op, in_rd, in_rs1, in_rs2;

    logic        rdy0, vld0, err0;
    logic [31:0] word0, addr0;
    logic        rdy1, vld1, err1;
    logic [31:0] word1;
    logic [3:0]  addr1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] w;
        int unsigned k;
    } ent_t;

    ent_t        q[$];
    int unsigned mk;
    logic        merr;

    always #5 clk = ~clk;

    inst_r_encoder dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(vld0), .out_ready(out_ready),
        .out_word(word0), .out_addr(addr0), .err(err0)
    );

    inst_r_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(vld1), .out_ready(out_ready),
        .out_word(word1), .out_addr(addr1), .err(err1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoding from the RV32I/M tables: returns {legal, word}.
    function automatic logic [32:0] ref_enc(input int op, input int rd, input int rs1, input int rs2);
        logic [6:0] f7;
        logic [2:0] f3;
        logic       ok;
        ok = 1'b1; f7 = 7'h00; f3 = 3'd0;
        case (op)
            0: f3 = 3'd0;
            1: begin f3 = 3'd0; f7 = 7'h20; end
            2: f3 = 3'd1;
            3: f3 = 3'd2;
            4: f3 = 3'd3;
            5: f3 = 3'd4;
            6: f3 = 3'd5;
            7: begin f3 = 3'd5; f7 = 7'h20; end
            8: f3 = 3'd6;
            9: f3 = 3'd7;
            default: begin
`ifdef INST_R_ENCODER_M_EXT_EN
                if (op >= 10 && op <= 17) begin
                    f7 = 7'h01;
                    f3 = 3'(op - 10);
                end else ok = 1'b0;
`else
                ok = 1'b0;
`endif
            end
        endcase
        return {ok, f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
    endfunction

    task automatic model_clear();
        q.delete();
        mk   = 0;
        merr = 1'b0;
    endtask

    task automatic check_outputs();
        chk("out_valid0", 64'(vld0), 64'(q.size() > 0));
        chk("out_valid1", 64'(vld1), 64'(q.size() > 0));
        chk("err0", 64'(err0), 64'(merr));
        chk("err1", 64'(err1), 64'(merr));
        if (q.size() > 0) begin
            chk("out_word0", 64'(word0), 64'(q[0].w));
            chk("out_word1", 64'(word1), 64'(q[0].w));
            chk("out_addr0", 64'(addr0), 64'(32'(q[0].k * 4)));
            chk("out_addr1", 64'(addr1), 64'(4'(12 + q[0].k * 4)));
        end
    endtask

    // Called at a falling edge; applies one cycle of inputs and checks after the next falling edge.
    task automatic step(input bit v, input int op, input int rd, input int rs1, input int rs2,
                        input bit ordy, input bit fl);
        logic [32:0] e;
        bit          acc, popm;
        in_valid  = v;
        in_op     = 5'(op);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        out_ready = ordy;
        flush     = fl;
        chk("in_ready0", 64'(rdy0), 64'(q.size() < 2));
        chk("in_ready1", 64'(rdy1), 64'(q.size() < 2));
        acc  = v && (q.size() < 2);
        popm = ordy && (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            if (popm) void'(q.pop_front());
            if (acc) begin
                e = ref_enc(op, rd, rs1, rs2);
                if (e[32]) begin
                    q.push_back('{w: e[31:0], k: mk});
                    mk++;
                end else merr = 1'b1;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 0, 0, 0, 0, ordy, 1'b0);
    endtask

    task automatic do_flush();
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(vld0), 64'd0);
        chk("rst_word", 64'(word0), 64'd0);
        chk("rst_addr0", 64'(addr0), 64'd0);
        chk("rst_addr1", 64'(addr1), 64'hC);
        chk("rst_err", 64'(err0), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(rdy0), 64'd1);

        // ADD then SUB with out_ready high: one per cycle, push+pop at count 1.
        step(1'b1, 0, 3, 1, 2, 1'b1, 1'b0);
        chk("add_word", 64'(word0), 64'h002081B3);
        chk("add_addr", 64'(addr0), 64'h0);
        step(1'b1, 1, 5, 6, 7, 1'b1, 1'b0);
        chk("sub_word", 64'(word0), 64'h407302B3);
        chk("sub_addr", 64'(addr0), 64'h4);
        idle(1'b1);

        // Backpressure: three requests with out_ready low; third held until drained.
        do_flush();
        step(1'b1, 5, 1, 2, 3, 1'b0, 1'b0);
        step(1'b1, 8, 4, 5, 6, 1'b0, 1'b0);
        chk("bp_ready_low", 64'(rdy0), 64'd0);
        step(1'b1, 9, 7, 8, 9, 1'b0, 1'b0);
        step(1'b1, 9, 7, 8, 9, 1'b0, 1'b0);
        chk("bp_hold_addr", 64'(addr0), 64'h0);
        step(1'b1, 9, 7, 8, 9, 1'b1, 1'b0);
        chk("bp_second_addr", 64'(addr0), 64'h4);
        step(1'b1, 9, 7, 8, 9, 1'b1, 1'b0);
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("bp_third_addr", 64'(addr0), 64'h8);
        idle(1'b1);

        // Illegal op: consumed, no entry, err sticky, address unchanged; flush clears.
        do_flush();
        step(1'b1, 20, 1, 1, 1, 1'b1, 1'b0);
        chk("ill_valid", 64'(vld0), 64'd0);
        chk("ill_err", 64'(err0), 64'd1);
        step(1'b1, 0, 3, 1, 2, 1'b1, 1'b0);
        chk("ill_next_addr", 64'(addr0), 64'h0);
        chk("ill_err_sticky", 64'(err0), 64'd1);
        do_flush();
        chk("flush_err", 64'(err0), 64'd0);
        step(1'b1, 2, 1, 1, 1, 1'b1, 1'b0);
        chk("flush_addr", 64'(addr0), 64'h0);
        idle(1'b1);

`ifdef INST_R_ENCODER_M_EXT_EN
        step(1'b1, 10, 1, 2, 3, 1'b1, 1'b0);
        chk("mul_word", 64'(word0), 64'h023100B3);
        idle(1'b1);
`endif

        // Narrow address wrap, then reset with two entries buffered.
        do_flush();
        step(1'b1, 0, 1, 1, 1, 1'b0, 1'b0);
        chk("wrap_first", 64'(addr1), 64'hC);
        step(1'b1, 3, 2, 2, 2, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid0", 64'(vld0), 64'd0);
        chk("rst_mid_valid1", 64'(vld1), 64'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
        chk("rst_mid_addr1", 64'(addr1), 64'hC);
        step(1'b1, 0, 1, 1, 1, 1'b1, 1'b0);
        step(1'b1, 4, 9, 9, 9, 1'b1, 1'b0);
        chk("wrap_second", 64'(addr1), 64'h0);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int op;
            op = ($urandom % 4 == 0) ? int'($urandom_range(31, 10)) : int'($urandom_range(9, 0));
            step(($urandom % 4) != 0, op, int'($urandom % 32), int'($urandom % 32),
                 int'($urandom % 32), ($urandom % 3) != 0, ($urandom % 40) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_r_encoder.md
INST_R_ENCODER -- requirements
Module: inst_r_encoder

Interface
REQ-001 Parameter ADDR_W, default 32: width of the instruction-memory byte address.
REQ-002 Parameter BASE_ADDR, default 0: first address emitted after reset or flush.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 flush  in  1  synchronous clear of buffer, address counter and error flag.
REQ-006 in_valid  in  1  request fields are valid.
REQ-007 in_ready  out  1  encoder can accept a request this cycle.
REQ-008 in_op  in  5  operation code (see REQ-013).
REQ-009 in_rd, in_rs1, in_rs2  in  5 each  destination and source register numbers.
REQ-010 out_valid  out  1  out_word/out_addr hold an encoded instruction.
REQ-011 out_ready  in  1  downstream consumes the current entry.
REQ-012 out_word  out  32  encoded R-type word; out_addr  out  ADDR_W  its byte address; err  out  1  sticky illegal-op flag.

Function
REQ-013 Base op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
REQ-014 Word = {funct7, rs2, rs1, funct3, rd, 7'b0110011}; rs2 in [24:20], rs1 in [19:15], rd in [11:7].
REQ-015 funct7 = 7'b0100000 for SUB and SRA; 7'b0000000 for all other base ops; funct3 per RV32I.
REQ-016 Handshake: a transfer occurs on any edge with valid and ready both high; in_valid is not required to wait for in_ready.
REQ-017 Buffering: 2-entry FIFO of {word, addr}; in_ready = (count < 2), derived from registered count only.
REQ-018 Latency: a request accepted at edge N is visible on the outputs after edge N when the FIFO was empty; out_word/out_addr are driven from FIFO registers, with no combinational path from the inputs.
REQ-019 Throughput: one instruction per cycle sustained when out_ready is held high; a simultaneous push and pop at count 1 leaves count at 1.
REQ-020 Address counter: starts at BASE_ADDR and increments by 4 on each accepted legal request; it wraps modulo 2^ADDR_W.
REQ-021 Illegal op (unsupported code): the request is accepted (handshake completes), no entry is enqueued, the address is unchanged, and err is set on the next edge.
REQ-022 err stays set until rst or flush.
REQ-023 out_word/out_addr remain stable while out_valid is high and out_ready is low.
REQ-024 flush has priority over push and pop in the same cycle: count goes to 0, the address counter goes to BASE_ADDR, err clears, and the request in that cycle is dropped.

Reset
REQ-025 While rst is high: count=0, out_valid=0, in_ready=1 (after release), err=0, address counter=BASE_ADDR, out_word=0, out_addr=BASE_ADDR.
REQ-026 rst asserted mid-transfer discards all buffered entries; no partial entry survives.

Configuration
REQ-027 Macro INST_R_ENCODER_M_EXT_EN defined: op codes 10-17 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, with funct7=7'b0000001 and funct3=0..7 respectively.
REQ-028 Macro undefined: op codes 10-31 are illegal (REQ-021).
REQ-029 Macro defined: op codes 18-31 are illegal.

Structure
REQ-030 Shared package inst_r_pkg holds: the OP_R opcode constant, the op-code enum, funct3/funct7 constants, and the M-extension constants under the same macro.
REQ-031 One sub-module, inst_r_fifo (2-entry, parameterised width), holds the buffer; the top level holds encode, counter and err logic.

Verification
REQ-032 ADD, rd=3, rs1=1, rs2=2, FIFO empty, out_ready=1 -> next cycle out_word=0x002081B3, out_addr=0x0.
REQ-033 SUB, rd=5, rs1=6, rs2=7 as the second legal request -> out_word=0x407302B3, out_addr=0x4.
REQ-034 out_ready=0 with three back-to-back requests -> in_ready low after the 2nd; the 3rd is held; then out_ready=1 drains words in order with addresses 0x0, 0x4, 0x8.
REQ-035 in_op=20, macro undefined -> handshake completes, no out_valid, err=1; next legal request is at the unchanged address; flush -> err=0 and address=BASE_ADDR.
REQ-036 Macro defined: MUL, rd=1, rs1=2, rs2=3 -> out_word=0x023100B3.
REQ-037 ADDR_W=4, BASE_ADDR=0xC, two legal requests -> out_addr 0xC then 0x0 (wrap); rst asserted with 2 entries buffered -> out_valid=0 immediately.
